// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module  : fetch_unit_pkg
// Brief   : Shared widths, fetch FSM state encoding, PCWrite codes and the
//           IF/ID payload struct used by the instruction-fetch stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [1:0] PCW_WRITE = 2'b00;
  localparam logic [1:0] PCW_HOLD  = 2'b01;

  // Laid out so the IF/ID register can capture it as a single word.
  typedef struct packed {
    logic valid;
    u64   pc;
    u32   instr;
    logic exc;
  } fetch_data_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module  : fetch_unit
// Brief   : Single-outstanding instruction fetch FSM with IF/ID handshake and
//           PCWrite control back to the PC register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int ILEN       = 32,
  parameter int ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_data_ok,
  input  logic [ILEN-1:0] iresp_data,
  output logic            f_valid,
  output logic [XLEN-1:0] f_pc,
  output logic [ILEN-1:0] f_instr,
  output logic            f_exc,
  input  logic            d_ready,
  output logic [1:0]      pc_stall
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic            exc_q, exc_d;
  fetch_data_t     fd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      instr_q    <= '0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      exc_q      <= exc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    exc_d      = exc_q;
    ireq_valid = 1'b0;
    ireq_addr  = '0;
    fd         = '0;
    pc_stall   = PCW_HOLD;

    case (state_q)
      IDLE: begin
        if (flush) begin
          pc_stall = PCW_WRITE;
        end else if (pc[ALIGN_BITS-1:0] != '0) begin
          // Misaligned PCs never reach the bus; they report straight to IF/ID.
          req_addr_d = pc;
          exc_d      = 1'b1;
          instr_d    = '0;
          state_d    = HOLD;
        end else begin
          req_addr_d = pc;
          exc_d      = 1'b0;
          state_d    = REQ;
        end
      end
      REQ: begin
        ireq_valid = 1'b1;
        ireq_addr  = req_addr_q;
        if (iresp_data_ok && flush) begin
          state_d  = IDLE;
          pc_stall = PCW_WRITE;
        end else if (iresp_data_ok) begin
          instr_d = iresp_data;
          state_d = HOLD;
        end else if (flush) begin
          state_d  = DRAIN;
          pc_stall = PCW_WRITE;
        end
      end
      DRAIN: begin
        // The stale request must still complete on the bus; its data is dropped.
        ireq_valid = 1'b1;
        ireq_addr  = req_addr_q;
        if (iresp_data_ok) state_d = IDLE;
        if (flush) pc_stall = PCW_WRITE;
      end
      HOLD: begin
        fd.valid = 1'b1;
        fd.pc    = u64'(req_addr_q);
        fd.instr = u32'(instr_q);
        fd.exc   = exc_q;
        if (flush || d_ready) begin
          state_d  = IDLE;
          pc_stall = PCW_WRITE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!reset) pc_stall = PCW_HOLD;
  end

  assign f_valid = fd.valid;
  assign f_pc    = fd.pc[XLEN-1:0];
  assign f_instr = fd.instr[ILEN-1:0];
  assign f_exc   = fd.exc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module  : tb_fetch_unit
// Brief   : Directed self-checking bench for fetch_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic        flush;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_instr;
  logic        f_exc;
  logic        d_ready;
  logic [1:0]  pc_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(64), .ILEN(32), .ALIGN_BITS(2)) dut (
    .clk(clk), .reset(reset), .pc(pc), .flush(flush),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .f_exc(f_exc),
    .d_ready(d_ready), .pc_stall(pc_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed and settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; pc = 64'h8000_0000; flush = 1'b0;
    iresp_data_ok = 1'b0; iresp_data = '0; d_ready = 1'b1;
    #3;
    chk("rst_ireq_valid", 64'(ireq_valid), 64'd0);
    chk("rst_f_valid",    64'(f_valid),    64'd0);
    chk("rst_pc_stall",   64'(pc_stall),   64'd1);

    // Basic fetch: data_ok in the second REQ cycle, accepted immediately.
    tick(); reset = 1'b1; #1;
    chk("idle_pc_stall", 64'(pc_stall), 64'd1);
    chk("idle_ireq",     64'(ireq_valid), 64'd0);
    tick(); #1;
    chk("req1_valid", 64'(ireq_valid), 64'd1);
    chk("req1_addr",  ireq_addr, 64'h8000_0000);
    tick(); iresp_data_ok = 1'b1; iresp_data = 32'h0000_0013; #1;
    chk("req2_addr",  ireq_addr, 64'h8000_0000);
    chk("req2_stall", 64'(pc_stall), 64'd1);
    chk("req2_fval",  64'(f_valid), 64'd0);
    tick(); iresp_data_ok = 1'b0; #1;
    chk("hold_fvalid", 64'(f_valid), 64'd1);
    chk("hold_fpc",    f_pc, 64'h8000_0000);
    chk("hold_finstr", 64'(f_instr), 64'h13);
    chk("hold_fexc",   64'(f_exc), 64'd0);
    chk("hold_stall",  64'(pc_stall), 64'd0);
    chk("hold_ireq",   64'(ireq_valid), 64'd0);

    // Backpressure: HOLD with d_ready low for four cycles.
    tick(); pc = 64'h8000_0004; #1;
    chk("idle2_fvalid", 64'(f_valid), 64'd0);
    tick(); iresp_data_ok = 1'b1; iresp_data = 32'h0010_0093; d_ready = 1'b0; #1;
    chk("req3_addr", ireq_addr, 64'h8000_0004);
    tick(); iresp_data_ok = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_fvalid%0d", i), 64'(f_valid), 64'd1);
      chk($sformatf("bp_fpc%0d", i),    f_pc, 64'h8000_0004);
      chk($sformatf("bp_finstr%0d", i), 64'(f_instr), 64'h0010_0093);
      chk($sformatf("bp_stall%0d", i),  64'(pc_stall), 64'd1);
      if (i < 3) tick();
    end
    tick(); d_ready = 1'b1; #1;
    chk("bp_accept_valid", 64'(f_valid), 64'd1);
    chk("bp_accept_stall", 64'(pc_stall), 64'd0);
    tick(); #1;
    chk("bp_idle_fvalid", 64'(f_valid), 64'd0);
    chk("bp_idle_ireq",   64'(ireq_valid), 64'd0);

    // Flush while the request at 0x8000_0004 is pending.
    tick(); flush = 1'b1; #1;
    chk("fl_req_addr",  ireq_addr, 64'h8000_0004);
    chk("fl_req_stall", 64'(pc_stall), 64'd0);
    tick(); flush = 1'b0; pc = 64'h8000_0100; #1;
    chk("drain1_valid", 64'(ireq_valid), 64'd1);
    chk("drain1_addr",  ireq_addr, 64'h8000_0004);
    chk("drain1_stall", 64'(pc_stall), 64'd1);
    chk("drain1_fval",  64'(f_valid), 64'd0);
    tick(); flush = 1'b1; #1;
    chk("drain2_addr",  ireq_addr, 64'h8000_0004);
    chk("drain2_stall", 64'(pc_stall), 64'd0);
    tick(); flush = 1'b0; iresp_data_ok = 1'b1; iresp_data = 32'hDEAD_BEEF; #1;
    chk("drain3_addr", ireq_addr, 64'h8000_0004);
    chk("drain3_fval", 64'(f_valid), 64'd0);
    tick(); iresp_data_ok = 1'b0; #1;
    chk("postdrain_ireq", 64'(ireq_valid), 64'd0);
    chk("postdrain_fval", 64'(f_valid), 64'd0);
    tick(); iresp_data_ok = 1'b1; iresp_data = 32'h0000_0073; #1;
    chk("redir_addr",  ireq_addr, 64'h8000_0100);
    chk("redir_valid", 64'(ireq_valid), 64'd1);
    tick(); iresp_data_ok = 1'b0; pc = 64'h8000_0002; #1;
    chk("redir_fpc",    f_pc, 64'h8000_0100);
    chk("redir_finstr", 64'(f_instr), 64'h73);

    // Misaligned PC: no bus request, exception delivered.
    tick(); #1;
    chk("mis_idle_ireq",  64'(ireq_valid), 64'd0);
    chk("mis_idle_stall", 64'(pc_stall), 64'd1);
    tick(); d_ready = 1'b1; flush = 1'b1; #1;
    chk("mis_ireq",   64'(ireq_valid), 64'd0);
    chk("mis_fvalid", 64'(f_valid), 64'd1);
    chk("mis_fexc",   64'(f_exc), 64'd1);
    chk("mis_finstr", 64'(f_instr), 64'd0);
    chk("mis_fpc",    f_pc, 64'h8000_0002);
    chk("mis_fl_stall", 64'(pc_stall), 64'd0);

    // Flush + d_ready in HOLD dropped; flush in IDLE holds there.
    tick(); #1;
    chk("flidle_fvalid", 64'(f_valid), 64'd0);
    chk("flidle_stall",  64'(pc_stall), 64'd0);
    tick(); flush = 1'b0; pc = 64'h8000_0200; #1;
    chk("flidle_ireq", 64'(ireq_valid), 64'd0);
    tick(); #1;
    chk("req200_addr", ireq_addr, 64'h8000_0200);

    // Asynchronous reset mid-REQ.
    #2 reset = 1'b0; #1;
    chk("arst_ireq",   64'(ireq_valid), 64'd0);
    chk("arst_fvalid", 64'(f_valid), 64'd0);
    chk("arst_stall",  64'(pc_stall), 64'd1);
    tick(); reset = 1'b1; pc = 64'h8000_0300; #1;
    chk("arst_idle_ireq", 64'(ireq_valid), 64'd0);
    tick(); #1;
    chk("arst_req_valid", 64'(ireq_valid), 64'd1);
    chk("arst_req_addr",  ireq_addr, 64'h8000_0300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
